// File: rtl/traffic_phase_sched.sv
// rtl/traffic_phase_sched.sv - two-street traffic light phase scheduler (Moore FSM)
// Optional pedestrian walk phase is built when TL_PED_PHASE_EN is defined.
module traffic_phase_sched #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       a,
  input  logic       b,
  input  logic       ped_req,
  output logic [2:0] La,
  output logic [2:0] Lb,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [2:0] A_GRN = 3'd0;
  localparam logic [2:0] A_YEL = 3'd1;
  localparam logic [2:0] AR1   = 3'd2;
  localparam logic [2:0] B_GRN = 3'd3;
  localparam logic [2:0] B_YEL = 3'd4;
  localparam logic [2:0] AR2   = 3'd5;
  localparam logic [2:0] PED   = 3'd6;

  localparam logic [2:0] LAMP_GRN = 3'b110;
  localparam logic [2:0] LAMP_YEL = 3'b100;
  localparam logic [2:0] LAMP_RED = 3'b111;

  localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_M1   = 8'(ALLRED_T - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       a_exit, b_exit;

  // A green may end once the minimum has elapsed and either its street is empty or the maximum is hit.
  assign a_exit = (timer_q >= GMIN_M1) && (!a || (timer_q == GMAX_M1));
  assign b_exit = (timer_q >= GMIN_M1) && (!b || (timer_q == GMAX_M1));

`ifdef TL_PED_PHASE_EN
  localparam logic [7:0] WALK_M1 = 8'(WALK_T - 1);
  logic ped_pend_q, ped_pend_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ped_pend_q <= 1'b0;
    else       ped_pend_q <= ped_pend_d;
  end

  // A new request in the same clk as the grant keeps the flag set for the next cycle.
  always_comb begin
    ped_pend_d = ped_req | (ped_pend_q & ~((state_q == AR2) && (state_d == PED)));
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= A_GRN;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GRN: if (tick && a_exit)              state_d = A_YEL;
      A_YEL: if (tick && (timer_q == YEL_M1)) state_d = AR1;
      AR1:   if (tick && (timer_q == AR_M1))  state_d = B_GRN;
      B_GRN: if (tick && b_exit)              state_d = B_YEL;
      B_YEL: if (tick && (timer_q == YEL_M1)) state_d = AR2;
`ifdef TL_PED_PHASE_EN
      AR2:   if (tick && (timer_q == AR_M1))  state_d = ped_pend_q ? PED : A_GRN;
      PED:   if (tick && (timer_q == WALK_M1)) state_d = A_GRN;
`else
      AR2:   if (tick && (timer_q == AR_M1))  state_d = A_GRN;
`endif
      default:                                state_d = A_GRN;
    endcase

    if (state_d != state_q) timer_d = 8'd0;
    else if (tick)          timer_d = timer_q + 8'd1;
    else                    timer_d = timer_q;
  end

  always_comb begin
    La       = LAMP_RED;
    Lb       = LAMP_RED;
    ped_walk = 1'b0;
    phase    = state_q;
    case (state_q)
      A_GRN: La = LAMP_GRN;
      A_YEL: La = LAMP_YEL;
      B_GRN: Lb = LAMP_GRN;
      B_YEL: Lb = LAMP_YEL;
`ifdef TL_PED_PHASE_EN
      PED:   ped_walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
